// File: rtl/interrupt_controller_if.sv
// Core-side handshake bundle for the interrupt controller.
// The core drives busy/ack/eret/pc; the controller drives request and status.
interface interrupt_controller_if;
    logic        int_req;
    logic [31:0] int_vector;
    logic [3:0]  int_cause;
    logic [31:0] epc;
    logic        in_service;
    logic        CPU_busy;
    logic        int_ack;
    logic        eret;
    logic [31:0] pc_in;

    modport master (
        input  int_req, int_vector, int_cause, epc, in_service,
        output CPU_busy, int_ack, eret, pc_in
    );

    modport slave (
        input  CPU_busy, int_ack, eret, pc_in,
        output int_req, int_vector, int_cause, epc, in_service
    );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritising edge-triggered interrupt front-end for the multi-cycle core.
// Holds NMI + 8 maskable sources pending and raises one vectored request.
module interrupt_controller #(
    parameter logic [31:0] NMI_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0180
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    NON_maskable_interrupt,
    input  logic [7:0]              irq_in,
    input  logic                    mask_we,
    input  logic [7:0]              mask_wdata,
    output logic [8:0]              pending,
    interrupt_controller_if.slave   core
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  line_prev;
    logic [8:0]  pend_q;
    logic [8:0]  edges;
    logic [8:0]  clr;
    logic [7:0]  mask_q;
    logic        sel_valid;
    logic [3:0]  sel_cause;
    logic [3:0]  cause_q;
    logic [31:0] vector_q;
    logic [31:0] epc_q;
    logic        take;
    logic        ack_ok;

    assign edges = {NON_maskable_interrupt, irq_in} & ~line_prev;
    assign clr   = ack_ok ? (9'd1 << cause_q) : 9'd0;

    // Pick NMI first, otherwise the lowest-index enabled pending irq.
    always_comb begin
        sel_valid = 1'b0;
        sel_cause = 4'd0;
        if (pend_q[8]) begin
            sel_valid = 1'b1;
            sel_cause = 4'd8;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pend_q[i] && mask_q[i]) begin
                    sel_valid = 1'b1;
                    sel_cause = 4'(i);
                end
            end
        end
    end

    // Next-state logic: request only at instruction boundaries, no nesting.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        ack_ok    = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_valid && !core.CPU_busy) begin
                    take      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (core.int_ack) begin
                    ack_ok    = 1'b1;
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (core.eret) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Edge history, pending set/clear (a new edge beats an ack clear) and mask.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_prev <= 9'd0;
            pend_q    <= 9'd0;
            mask_q    <= 8'h00;
        end else begin
            line_prev <= {NON_maskable_interrupt, irq_in};
            pend_q    <= (pend_q & ~clr) | edges;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // Freeze cause/vector when a request is launched; grab the PC on ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            cause_q  <= 4'd0;
            vector_q <= 32'd0;
            epc_q    <= 32'd0;
        end else begin
            if (take) begin
                cause_q <= sel_cause;
                if (sel_cause == 4'd8) begin
                    vector_q <= NMI_VECTOR;
                end else begin
                    vector_q <= VECTOR_BASE + (32'(sel_cause) << 3);
                end
            end
            if (ack_ok) begin
                epc_q <= core.pc_in;
            end
        end
    end

    assign core.int_req    = (state == REQ);
    assign core.in_service = (state == SERVICE);
    assign core.int_cause  = cause_q;
    assign core.int_vector = vector_q;
    assign core.epc        = epc_q;
    assign pending         = pend_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed plan + random traffic,
// checked every cycle against a rule-level reference model.
module tb_interrupt_controller;

    logic       clock;
    logic       reset;
    logic       nmi;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [8:0] pending;

    interrupt_controller_if core_if();

    interrupt_controller dut (
        .clock                  (clock),
        .reset                  (reset),
        .NON_maskable_interrupt (nmi),
        .irq_in                 (irq_in),
        .mask_we                (mask_we),
        .mask_wdata             (mask_wdata),
        .pending                (pending),
        .core                   (core_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [8:0]  m_lines_old;
    logic [8:0]  m_pend;
    logic [7:0]  m_mask;
    logic        m_req;
    logic        m_svc;
    logic [3:0]  m_cause;
    logic [31:0] m_vec;
    logic [31:0] m_epc;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the interrupt rules, using inputs seen at this edge.
    task automatic model_step();
        logic [8:0] lines;
        logic [8:0] rises;
        int         who;
        lines = {nmi, irq_in};
        if (reset) begin
            m_lines_old = 9'd0;
            m_pend      = 9'd0;
            m_mask      = 8'h00;
            m_req       = 1'b0;
            m_svc       = 1'b0;
            m_cause     = 4'd0;
            m_vec       = 32'd0;
            m_epc       = 32'd0;
            return;
        end
        rises = lines & ~m_lines_old;
        if (m_req) begin
            if (core_if.int_ack) begin
                m_pend[m_cause] = 1'b0;
                m_epc = core_if.pc_in;
                m_req = 1'b0;
                m_svc = 1'b1;
            end
        end else if (m_svc) begin
            if (core_if.eret) m_svc = 1'b0;
        end else if (!core_if.CPU_busy) begin
            who = -1;
            if (m_pend[8]) who = 8;
            else
                for (int i = 0; i < 8; i++)
                    if (who < 0 && m_pend[i] && m_mask[i]) who = i;
            if (who >= 0) begin
                m_req   = 1'b1;
                m_cause = 4'(who);
                m_vec   = (who == 8) ? 32'h100 : 32'h180 + 32'(who * 8);
            end
        end
        m_pend      = m_pend | rises;
        m_lines_old = lines;
        if (mask_we) m_mask = mask_wdata;
    endtask

    task automatic compare_all();
        check("int_req",    32'(core_if.int_req),    32'(m_req));
        check("in_service", 32'(core_if.in_service), 32'(m_svc));
        check("int_cause",  32'(core_if.int_cause),  32'(m_cause));
        check("int_vector", core_if.int_vector,      m_vec);
        check("epc",        core_if.epc,             m_epc);
        check("pending",    32'(pending),            32'(m_pend));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic do_ack(input logic [31:0] pc);
        core_if.pc_in   = pc;
        core_if.int_ack = 1'b1;
        tick();
        core_if.int_ack = 1'b0;
    endtask

    task automatic do_eret();
        core_if.eret = 1'b1;
        tick();
        core_if.eret = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        nmi                = 1'b0;
        irq_in             = 8'h00;
        mask_we            = 1'b0;
        mask_wdata         = 8'h00;
        core_if.CPU_busy   = 1'b0;
        core_if.int_ack    = 1'b0;
        core_if.eret       = 1'b0;
        core_if.pc_in      = 32'd0;

        tick();
        tick();
        check("rst_req",  32'(core_if.int_req), 32'd0);
        check("rst_pend", 32'(pending),         32'd0);
        check("rst_vec",  core_if.int_vector,   32'd0);
        reset = 1'b0;
        tick();

        // masked irq2 path
        write_mask(8'h04);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        check("s1_lat1", 32'(core_if.int_req), 32'd0);
        tick();
        check("s1_req",   32'(core_if.int_req),   32'd1);
        check("s1_cause", 32'(core_if.int_cause), 32'd2);
        check("s1_vec",   core_if.int_vector,     32'h190);
        do_ack(32'h40);
        check("s1_epc",  core_if.epc,              32'h40);
        check("s1_pend", 32'(pending[2]),          32'd0);
        check("s1_svc",  32'(core_if.in_service),  32'd1);
        do_eret();

        // NMI beats irq5, irq5 follows after eret
        write_mask(8'hFF);
        irq_in = 8'h20;
        nmi    = 1'b1;
        tick();
        irq_in = 8'h00;
        nmi    = 1'b0;
        tick();
        check("s2_cause", 32'(core_if.int_cause), 32'd8);
        check("s2_vec",   core_if.int_vector,     32'h100);
        do_ack(32'h80);
        do_eret();
        check("s2_gap", 32'(core_if.int_req), 32'd0);
        tick();
        check("s2_cause2", 32'(core_if.int_cause), 32'd5);
        check("s2_vec2",   core_if.int_vector,     32'h1A8);
        do_ack(32'h84);
        do_eret();

        // mask gates selection but keeps pending
        write_mask(8'h00);
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
        check("s3_pend", 32'(pending[1]),       32'd1);
        check("s3_noreq", 32'(core_if.int_req), 32'd0);
        write_mask(8'h02);
        check("s3_wait", 32'(core_if.int_req), 32'd0);
        tick();
        check("s3_req",   32'(core_if.int_req),   32'd1);
        check("s3_cause", 32'(core_if.int_cause), 32'd1);
        do_ack(32'h90);
        do_eret();

        // busy holds off the request, but not once raised
        write_mask(8'h08);
        core_if.CPU_busy = 1'b1;
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s4_busy", 32'(core_if.int_req), 32'd0);
        end
        core_if.CPU_busy = 1'b0;
        tick();
        check("s4_req", 32'(core_if.int_req), 32'd1);
        core_if.CPU_busy = 1'b1;
        tick();
        check("s4_hold", 32'(core_if.int_req), 32'd1);
        do_ack(32'hA0);
        core_if.CPU_busy = 1'b0;
        check("s4_svc", 32'(core_if.in_service), 32'd1);
        do_eret();

        // NMI during service waits; re-edge on acked bit survives
        write_mask(8'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        do_ack(32'hB0);
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        tick();
        check("s5_noreq", 32'(core_if.int_req), 32'd0);
        check("s5_pend",  32'(pending[8]),      32'd1);
        do_eret();
        check("s5_gap", 32'(core_if.int_req), 32'd0);
        tick();
        check("s5_req",   32'(core_if.int_req),   32'd1);
        check("s5_cause", 32'(core_if.int_cause), 32'd8);
        nmi = 1'b1;
        do_ack(32'hB4);
        nmi = 1'b0;
        check("s5_keep", 32'(pending[8]), 32'd1);
        do_eret();
        tick();
        do_ack(32'hB8);
        do_eret();

        // reset mid-request, line held across release
        write_mask(8'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        check("s6_req", 32'(core_if.int_req), 32'd1);
        reset  = 1'b1;
        irq_in = 8'h01;
        tick();
        check("s6_rreq",  32'(core_if.int_req), 32'd0);
        check("s6_rpend", 32'(pending),         32'd0);
        reset = 1'b0;
        tick();
        check("s6_pend0", 32'(pending),         32'h001);
        check("s6_mask0", 32'(core_if.int_req), 32'd0);
        tick();
        check("s6_still", 32'(core_if.int_req), 32'd0);
        irq_in = 8'h00;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            reset            = ($urandom % 300) == 0;
            nmi              = ($urandom % 16) == 0;
            irq_in           = 8'($urandom & $urandom & $urandom);
            mask_we          = ($urandom % 20) == 0;
            mask_wdata       = 8'($urandom);
            core_if.CPU_busy = ($urandom % 3) == 0;
            core_if.int_ack  = core_if.int_req ?
                               (($urandom % 3) == 0) : (($urandom % 25) == 0);
            core_if.eret     = core_if.in_service ?
                               (($urandom % 4) == 0) : (($urandom % 25) == 0);
            core_if.pc_in    = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
